// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the display blocks.
// Patterns are active-low, with bit order g..a (bit6 = g, bit0 = a).
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [6:0] seg7_lookup(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-segment decoder (active-low output, bits g..a).
// Other display blocks reuse it alongside the shared table.
module seg7_decoder (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_n
);
    import seg7_pkg::*;

    assign o_seg_n = seg7_lookup(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: a prescaler tick steps the digit index,
// the frame is latched into a shadow copy at wrap, and all pins are registered.
module seg7_scan_driver #(
    parameter logic [31:0] DIVIDER = 32'd3,
    parameter int          DIGITS  = 4
) (
    input  logic                clk_ref,
    input  logic                rst,
    input  logic                enable,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    output logic [6:0]          seg_n,
    output logic                dp_n,
    output logic [DIGITS-1:0]   an_n,
    output logic                frame_done
);
    import seg7_pkg::*;

    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [31:0]         r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]   r_shadow_dp;

    logic [DIGITS-1:0]   r_an_n;
    logic [6:0]          r_seg_n;
    logic                r_dp_n;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_wrap;
    logic [IDX_W-1:0]    w_idx_next;
    logic [4*DIGITS-1:0] w_shadow_next;
    logic [DIGITS-1:0]   w_shadow_dp_next;
    logic [3:0]          w_nibble;
    logic                w_dp_sel;
    logic [DIGITS-1:0]   w_an_sel;
    logic [6:0]          w_seg_dec;

    assign w_tick = enable && (r_cnt == DIVIDER);
    assign w_wrap = w_tick && (r_idx == LAST_IDX);

    always_comb begin
        w_idx_next = r_idx;
        if (w_tick) begin
            w_idx_next = w_wrap ? '0 : r_idx + 1'b1;
        end
    end

    assign w_shadow_next    = w_wrap ? value : r_shadow;
    assign w_shadow_dp_next = w_wrap ? dp_in : r_shadow_dp;

    // Output stage looks at the upcoming digit so the dead-time cycle already
    // carries the new segment pattern while the anodes are still off.
    always_comb begin
        w_nibble = '0;
        w_dp_sel = 1'b0;
        w_an_sel = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_idx_next == IDX_W'(k)) begin
                w_nibble    = w_shadow_next[4*k +: 4];
                w_dp_sel    = w_shadow_dp_next[k];
                w_an_sel[k] = 1'b0;
            end
        end
    end

    seg7_decoder u_decoder (
        .i_nibble (w_nibble),
        .o_seg_n  (w_seg_dec)
    );

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_shadow_dp <= '0;
        end else if (enable) begin
            r_cnt       <= w_tick ? '0 : r_cnt + 32'd1;
            r_idx       <= w_idx_next;
            r_shadow    <= w_shadow_next;
            r_shadow_dp <= w_shadow_dp_next;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            r_an_n       <= '1;
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else if (enable) begin
            r_an_n       <= w_tick ? '1 : w_an_sel;
            r_seg_n      <= w_seg_dec;
            r_dp_n       <= ~w_dp_sel;
            r_frame_done <= w_wrap;
        end else begin
            r_an_n       <= '1;
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus randomized traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_seg7_scan_driver;

    localparam logic [31:0] DIVIDER = 32'd3;
    localparam int          DIGITS  = 4;

    logic        clk_ref = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int unsigned m_cnt  = 0;
    int          m_idx  = 0;
    logic [15:0] m_sh   = '0;
    logic [3:0]  m_shdp = '0;
    logic [3:0]  e_an   = 4'hF;
    logic [6:0]  e_seg  = 7'h7F;
    logic        e_dp   = 1'b1;
    logic        e_fd   = 1'b0;

    seg7_scan_driver #(
        .DIVIDER (DIVIDER),
        .DIGITS  (DIGITS)
    ) dut (
        .clk_ref    (clk_ref),
        .rst        (rst),
        .enable     (enable),
        .value      (value),
        .dp_in      (dp_in),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model of one clock edge: state updates, then the pin values for the next cycle.
    task automatic model_edge();
        logic        tick;
        logic [15:0] sh;
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_sh = '0; m_shdp = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else if (!enable) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            tick = (m_cnt == DIVIDER);
            e_fd = tick && (m_idx == DIGITS - 1);
            if (tick) begin
                m_cnt = 0;
                if (m_idx == DIGITS - 1) begin
                    m_sh   = value;
                    m_shdp = dp_in;
                end
                m_idx = (m_idx + 1) % DIGITS;
            end else begin
                m_cnt++;
            end
            sh    = m_sh >> (4 * m_idx);
            e_an  = tick ? 4'hF : ~(4'b0001 << m_idx);
            e_seg = seg_ref[sh[3:0]];
            e_dp  = ~m_shdp[m_idx];
        end
    endtask

    task automatic step();
        @(posedge clk_ref);
        model_edge();
        @(negedge clk_ref);
        chk("m_an",  32'(an_n),       32'(e_an));
        chk("m_seg", 32'(seg_n),      32'(e_seg));
        chk("m_dp",  32'(dp_n),       32'(e_dp));
        chk("m_fd",  32'(frame_done), 32'(e_fd));
    endtask

    task automatic wait_an(input logic [3:0] target, input string tag);
        int n = 0;
        while (an_n !== target && n < 64) begin
            step();
            n++;
        end
        chk(tag, 32'(an_n), 32'(target));
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        chk(tag, 32'(frame_done), 32'd1);
    endtask

    initial begin
        logic [6:0]  seen_seg [4];
        logic        seen_dp  [4];
        logic [6:0]  cap_seg  [4];
        logic        cap_dp   [4];
        logic [3:0]  exp_an;
        logic [3:0]  an_before;
        logic [31:0] r;
        int          n_fd;
        int          n_act;
        int          en_hold;

        cap_seg = '{7'b0001110, 7'b0100100, 7'b0001000, 7'b1111001};
        cap_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; enable = 1'b0; value = '0; dp_in = '0;
        step();
        step();
        chk("rst_an",  32'(an_n),       32'(4'hF));
        chk("rst_seg", 32'(seg_n),      32'(7'h7F));
        chk("rst_dp",  32'(dp_n),       32'd1);
        chk("rst_fd",  32'(frame_done), 32'd0);

        rst = 1'b0; enable = 1'b1;
        step();
        chk("first_an",  32'(an_n),  32'(4'b1110));
        chk("first_seg", 32'(seg_n), 32'(7'b1000000));

        // Scan order: cycle c after release, dead time on every 4th cycle.
        n_fd = 0;
        for (int c = 2; c <= 33; c++) begin
            step();
            exp_an = (c % 4 == 0) ? 4'hF : ~(4'b0001 << ((c / 4) % 4));
            chk("scan_an", 32'(an_n), 32'(exp_an));
            chk("scan_fd", 32'(frame_done), 32'((c % 16) == 0));
            if (frame_done === 1'b1) n_fd++;
        end
        chk("scan_fd_count", 32'(n_fd), 32'd2);

        // Frame capture: new data mid-frame must wait for the wrap.
        wait_an(4'b1101, "cap_sync");
        value = 16'h1A2F; dp_in = 4'b0100;
        n_act = 0;
        while (frame_done !== 1'b1 && n_act < 40) begin
            step();
            n_act++;
            if (frame_done !== 1'b1 && an_n !== 4'hF)
                chk("cap_prewrap_seg", 32'(seg_n), 32'(7'b1000000));
        end
        chk("cap_wrap_fd", 32'(frame_done), 32'd1);
        for (int k = 0; k < 4; k++) begin
            seen_seg[k] = 7'h00;
            seen_dp[k]  = 1'bx;
        end
        for (int i = 0; i < 16; i++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (an_n === ~(4'b0001 << k)) begin
                    seen_seg[k] = seg_n;
                    seen_dp[k]  = dp_n;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk("cap_seg", 32'(seen_seg[k]), 32'(cap_seg[k]));
            chk("cap_dp",  32'(seen_dp[k]),  32'(cap_dp[k]));
        end

        // Freeze on the first active cycle of a digit, then resume.
        wait_an(4'hF, "frz_sync");
        step();
        an_before = an_n;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("frz_an",  32'(an_n),       32'(4'hF));
            chk("frz_seg", 32'(seg_n),      32'(7'h7F));
            chk("frz_dp",  32'(dp_n),       32'd1);
            chk("frz_fd",  32'(frame_done), 32'd0);
        end
        enable = 1'b1;
        step();
        chk("resume_an", 32'(an_n), 32'(an_before));
        n_act = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (an_n === 4'hF) break;
            n_act++;
        end
        chk("resume_active_len", 32'(n_act), 32'd2);

        // Reset while digit 2 is on: no frame_done, reset values next cycle.
        wait_an(4'b1011, "mrst_sync");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_an",  32'(an_n),       32'(4'hF));
        chk("mrst_seg", 32'(seg_n),      32'(7'h7F));
        chk("mrst_dp",  32'(dp_n),       32'd1);
        chk("mrst_fd",  32'(frame_done), 32'd0);
        n_fd = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (frame_done === 1'b1) n_fd++;
        end
        chk("mrst_no_fd", 32'(n_fd), 32'd0);

        // Every nibble on digit 0.
        for (int n = 0; n < 16; n++) begin
            r = $urandom();
            value = {r[11:0], 4'(n)};
            dp_in = r[15:12];
            wait_fd("dec_fd");
            step();
            chk("dec_an",  32'(an_n),  32'(4'b1110));
            chk("dec_seg", 32'(seg_n), 32'(seg_ref[n]));
        end

        // Randomized traffic with enable drops and occasional resets.
        en_hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                value = 16'($urandom());
                dp_in = 4'($urandom());
            end
            if (en_hold > 0) en_hold--;
            else if ($urandom_range(0, 31) == 0) en_hold = $urandom_range(1, 12);
            enable = (en_hold == 0);
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
